// File: rtl/serial_feed_if.sv
// serial_feed word/bit handshake bundle: slave = serializer, master = upstream source plus downstream observer.
// No logic and no latency; back-pressure is carried on ready_out.
interface serial_feed_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             dout;
  logic             dout_valid;
  logic             busy;

  modport master (output data_in, valid_in, input ready_out, dout, dout_valid, busy);
  modport slave  (input data_in, valid_in, output ready_out, dout, dout_valid, busy);
endinterface

// File: rtl/serial_feed.sv
// serial_feed: WIDTH-bit words (valid/ready, one word of look-ahead) to 1 bit/clk on dout; first bit 1 clk after the accept edge.
// ready_out drops while a word is pending. SERIAL_FEED_PARITY_EN appends an even-parity bit per word.
module serial_feed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_,
  serial_feed_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1) + 1;

`ifdef SERIAL_FEED_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_dout;
  logic             r_dout_vld;

  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_rl_load;
  logic             w_load;
  logic             w_load_pend;
  logic             w_to_pend;
  logic             w_bit;
  logic             w_dout_nxt;
  logic             w_vld_nxt;
  logic [WIDTH-1:0] w_load_word;

  assign w_accept    = bus.valid_in & ~r_pend_vld;
  assign w_last      = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  // At a frame boundary the next word comes from pending if present, else straight from an accept.
  assign w_rl_load   = r_pend_vld | w_accept;
  assign w_bit       = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_load_word = w_load_pend ? r_pend : bus.data_in;

`ifdef SERIAL_FEED_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_load_word;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_pend = 1'b0;
    w_to_pend   = 1'b0;
    w_dout_nxt  = 1'b0;
    w_vld_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_dout_nxt = w_bit;
        w_vld_nxt  = 1'b1;
        if (w_last) begin
`ifdef SERIAL_FEED_PARITY_EN
          w_state_nxt = S_PARITY;
          w_to_pend   = w_accept;
`else
          w_load      = w_rl_load;
          w_load_pend = r_pend_vld;
          w_state_nxt = w_rl_load ? S_SHIFT : S_IDLE;
`endif
        end else begin
          w_to_pend = w_accept;
        end
      end
`ifdef SERIAL_FEED_PARITY_EN
      S_PARITY: begin
        w_dout_nxt  = r_par;
        w_vld_nxt   = 1'b1;
        w_load      = w_rl_load;
        w_load_pend = r_pend_vld;
        w_state_nxt = w_rl_load ? S_SHIFT : S_IDLE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_dout     <= 1'b0;
      r_dout_vld <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift <= w_load_word;
        r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_to_pend) begin
        r_pend     <= bus.data_in;
        r_pend_vld <= 1'b1;
      end else if (w_load_pend) begin
        r_pend_vld <= 1'b0;
      end
      r_dout     <= w_dout_nxt;
      r_dout_vld <= w_vld_nxt;
    end
  end

  assign bus.ready_out  = ~r_pend_vld;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_vld;
  assign bus.busy       = (r_state != S_IDLE) | r_pend_vld;
endmodule

// File: tb/tb_serial_feed.sv
// Bench for serial_feed: MSB-first and LSB-first instances share stimulus; expected bits are queued at each handshake.
`timescale 1ns/1ps
module tb_serial_feed;
  localparam int W = 8;
`ifdef SERIAL_FEED_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  serial_feed_if #(.WIDTH(W)) if_m ();
  serial_feed_if #(.WIDTH(W)) if_l ();

  serial_feed #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst_(rst_), .bus(if_m));
  serial_feed #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst_(rst_), .bus(if_l));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   vld_cnt = 0;
  int   hs_cnt  = 0;
  logic q_m[$];
  logic q_l[$];
  bit   strm_m = 1'b0;
  bit   strm_l = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      q_m.push_back(w[W-1-k]);
      q_l.push_back(w[k]);
    end
`ifdef SERIAL_FEED_PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds valid_in high until the word is taken; leaves valid_in asserted for back-to-back use.
  task automatic xfer(input logic [W-1:0] w);
    bit done = 1'b0;
    if_m.data_in  = w;
    if_l.data_in  = w;
    if_m.valid_in = 1'b1;
    if_l.valid_in = 1'b1;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      if (if_m.ready_out === 1'b1) begin
        push_exp(w);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("accept", {31'd0, done}, 32'd1);
  endtask

  task automatic idle();
    if_m.valid_in = 1'b0;
    if_l.valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6 * FRAME && (q_m.size() != 0 || q_l.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_qm_empty"}, q_m.size(), 0);
    check({tag, "_ql_empty"}, q_l.size(), 0);
    check({tag, "_vld_end"}, if_m.dout_valid, 1'b0);
    check({tag, "_busy_end"}, if_m.busy, 1'b0);
    check({tag, "_rdy_end"}, if_m.ready_out, 1'b1);
  endtask

  always @(posedge clk) begin
    if (if_m.valid_in === 1'b1 && if_m.ready_out === 1'b1) hs_cnt++;
  end

  always @(negedge clk) begin
    if (if_m.dout_valid === 1'b1) begin
      vld_cnt++;
      if (q_m.size() == 0) begin
        check("m_extra_bit", if_m.dout_valid, 1'b0);
      end else begin
        check("m_bit", if_m.dout, q_m.pop_front());
        strm_m = (q_m.size() != 0);
      end
    end else if (strm_m) begin
      check("m_gap", if_m.dout_valid, 1'b1);
      strm_m = 1'b0;
    end
    if (if_l.dout_valid === 1'b1) begin
      if (q_l.size() == 0) begin
        check("l_extra_bit", if_l.dout_valid, 1'b0);
      end else begin
        check("l_bit", if_l.dout, q_l.pop_front());
        strm_l = (q_l.size() != 0);
      end
    end else if (strm_l) begin
      check("l_gap", if_l.dout_valid, 1'b1);
      strm_l = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_m.data_in  = '0;
    if_l.data_in  = '0;
    if_m.valid_in = 1'b0;
    if_l.valid_in = 1'b0;
    #12;
    check("rst_dout", if_m.dout, 1'b0);
    check("rst_vld", if_m.dout_valid, 1'b0);
    check("rst_busy", if_m.busy, 1'b0);
    check("rst_rdy", if_m.ready_out, 1'b1);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    cycles(1);

    // Single word, first-bit latency.
    xfer(8'h99);
    idle();
    check("lat_vld_pre", if_m.dout_valid, 1'b0);
    check("lat_busy", if_m.busy, 1'b1);
    cycles(1);
    check("lat_vld_first", if_m.dout_valid, 1'b1);
    check("lat_first_bit", if_m.dout, 1'b1);
    drain("w99");

    xfer(8'h01);
    idle();
    drain("w01");

    // valid_in held high across three words.
    vld_cnt = 0;
    hs_cnt  = 0;
    xfer(8'hA5);
    xfer(8'h3C);
    check("pend_rdy_low", if_m.ready_out, 1'b0);
    check("pend_busy", if_m.busy, 1'b1);
    xfer(8'hFF);
    idle();
    drain("b2b3");
    check("b2b3_vld_cycles", vld_cnt, 3 * FRAME);
    check("b2b3_handshakes", hs_cnt, 3);

    // Accept on the final-bit edge with pending empty.
    vld_cnt = 0;
    xfer(8'h5A);
    idle();
    cycles(FRAME - 1);
    check("last_rdy_pre", if_m.ready_out, 1'b1);
    xfer(8'hC3);
    idle();
    check("last_no_pend", if_m.ready_out, 1'b1);
    drain("lastbit");
    check("lastbit_vld_cycles", vld_cnt, 2 * FRAME);

    // Reset mid-frame with a word pending.
    xfer(8'hF0);
    xfer(8'hAA);
    idle();
    cycles(2);
    @(negedge clk);
    #1;
    check("pre_rst_vld", if_m.dout_valid, 1'b1);
    check("pre_rst_rdy", if_m.ready_out, 1'b0);
    rst_ = 1'b0;
    #1;
    check("arst_dout", if_m.dout, 1'b0);
    check("arst_vld", if_m.dout_valid, 1'b0);
    check("arst_busy", if_m.busy, 1'b0);
    check("arst_rdy", if_m.ready_out, 1'b1);
    check("arst_l_vld", if_l.dout_valid, 1'b0);
    q_m.delete();
    q_l.delete();
    strm_m = 1'b0;
    strm_l = 1'b0;
    cycles(2);
    rst_ = 1'b1;
    cycles(2);
    check("post_rst_busy", if_m.busy, 1'b0);
    check("post_rst_vld", if_m.dout_valid, 1'b0);
    xfer(8'h0F);
    idle();
    drain("w0F");

    // Parity-bearing words (plain frames in the default build).
    vld_cnt = 0;
    xfer(8'h07);
    xfer(8'h03);
    idle();
    drain("w07_03");
    check("w07_03_vld_cycles", vld_cnt, 2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
